// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath blocks.
//   DIV_WIDTH    : default operand width for the divider
//   div_state_e  : divider control states (S_IDLE, S_BUSY, S_DONE)
//   DBZ_FILL_BIT : bit replicated across the quotient on divide-by-zero
package arith_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  localparam bit DBZ_FILL_BIT = 1'b1;

endpackage

// File: rtl/cond_subtractor.sv
// One restoring-division step.
// Shifts the next dividend bit into the partial remainder, subtracts the divisor,
// and keeps the difference only if it did not borrow.
//   i_rem      : current partial remainder (always < divisor)
//   i_q_msb    : next dividend bit shifted in (MSB of the quotient/dividend register)
//   i_divisor  : divisor
//   o_rem_next : next partial remainder
//   o_q_bit    : quotient bit for this step (inverted borrow)
module cond_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem_next,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_diff;

  always_comb begin
    w_diff  = {i_rem, i_q_msb} - {1'b0, i_divisor};
    o_q_bit = ~w_diff[WIDTH];
    // Either choice is < divisor, so the top bit of the WIDTH+1 remainder is always
    // zero and only the low WIDTH bits are carried forward.
    o_rem_next = o_q_bit ? w_diff[WIDTH-1:0] : {i_rem[WIDTH-2:0], i_q_msb};
  end

endmodule

// File: rtl/divider_8x8.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (dividend, divisor)
//   out_valid / out_ready: result handshake (quotient, remainder, div_by_zero)
// Divide-by-zero skips the iteration and returns all-ones quotient, remainder=dividend.
module divider_8x8
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e      r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_r;
  logic [CntW-1:0]  r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_q_next;

  cond_subtractor #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem      (r_r),
    .i_q_msb    (r_q[WIDTH-1]),
    .i_divisor  (r_d),
    .o_rem_next (w_rem_next),
    .o_q_bit    (w_q_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign w_q_next = {r_q[WIDTH-2:0], w_q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_q        <= dividend;
            r_d        <= divisor;
            r_r        <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            if (divisor == '0) begin
              r_quotient  <= {WIDTH{DBZ_FILL_BIT}};
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_q     <= w_q_next;
          r_r     <= w_rem_next;
          r_count <= r_count + CntW'(1);
          if (r_count == CntW'(WIDTH - 1)) begin
            // Result registers are written only here so they stay stable between ops.
            r_quotient  <= w_q_next;
            r_remainder <= w_rem_next;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_8x8.sv
// Randomized self-checking bench for divider_8x8 with directed corner cases.
module tb_divider_8x8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  divider_8x8 #(
    .WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference for the companion multiplier: just the arithmetic product.
  function automatic logic [15:0] vedic_mul(input logic [7:0] a, input logic [7:0] b);
    return 16'(a) * 16'(b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE. Latency is counted in edges from the cycle
  // in_valid is presented (the accept edge is edge 1).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                        input bit strict);
    int          edges;
    logic [7:0]  exp_q;
    logic [7:0]  exp_r;
    logic        exp_z;
    exp_z = (b == 8'd0);
    exp_q = exp_z ? 8'hFF : a / b;
    exp_r = exp_z ? a : a % b;

    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    tick();
    in_valid  = 1'b0;
    dividend  = 8'($urandom);
    divisor   = 8'($urandom);
    edges     = 1;
    while (!out_valid && edges < 40) begin
      out_ready = 1'($urandom_range(0, 1));
      if (strict) begin
        in_valid = 1'b1;
        check("in_ready_busy", 32'(in_ready), 32'd0);
      end
      tick();
      edges++;
    end
    in_valid = 1'b0;
    check("latency", 32'(edges), exp_z ? 32'd1 : 32'd9);
    check("out_valid_rise", 32'(out_valid), 32'd1);

    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (strict) begin
        in_valid = 1'b1;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end
      tick();
      if (strict) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_q", 32'(quotient), 32'(exp_q));
        check("hold_r", 32'(remainder), 32'(exp_r));
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
    end
    in_valid = 1'b0;

    check("quotient", 32'(quotient), 32'(exp_q));
    check("remainder", 32'(remainder), 32'(exp_r));
    check("div_by_zero", 32'(div_by_zero), 32'(exp_z));
    if (!exp_z) begin
      check("identity", 32'(vedic_mul(quotient, b)) + 32'(remainder), 32'(a));
      check("rem_lt_div", 32'(remainder < b), 32'd1);
    end

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_fall", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 8'd0;
    divisor   = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);

    run_op(8'd100, 8'd7, 0, 1'b0);
    run_op(8'd255, 8'd1, 0, 1'b0);
    run_op(8'd200, 8'd255, 0, 1'b0);
    run_op(8'd5, 8'd0, 0, 1'b0);
    run_op(8'd0, 8'd9, 5, 1'b1);

    // Reset in the middle of BUSY, after four restoring steps.
    in_valid = 1'b1;
    dividend = 8'd250;
    divisor  = 8'd3;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("mid_busy_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_quotient", 32'(quotient), 32'd0);
    check("mid_rst_remainder", 32'(remainder), 32'd0);
    run_op(8'd250, 8'd3, 0, 1'b0);

    // Random sample of the operand space with random result stalls.
    for (int n = 0; n < 3000; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      run_op(ra, rb, $urandom_range(0, 3), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
